seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Time-multiplexed scanner for the 4-digit 7-segment display. Holds four BCD/hex
//  nibbles, cycles one active-low anode at a time, and presents the selected
//  nibble on number[3:0] to the per-digit segment decoder directly downstream.
//  Double-buffers digit updates so a new value is only shown at a frame boundary.
//  Supports per-digit blinking, used for reel/score highlighting.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles per digit slot (100 MHz -> 2 kHz/digit, 500 Hz frame)
//  BLINK_FRAMES  250    frames per blink half-period (500 Hz frame -> 0.5 s on/off)
// PORTS
//  clk        in   1   system clock; every flop is clocked on its rising edge
//  rst        in   1   asynchronous, active-high reset
//  digits_in  in   16  {d3,d2,d1,d0}; d0 = rightmost digit, captured when load=1
//  load       in   1   1-cycle request to capture digits_in into the pending buffer
//  blink_en   in   4   per-digit blink enable; bit i controls digit i; sampled live
//  number     out  4   nibble of the currently scanned digit, to the segment decoder
//  an         out  4   anode enables, active low, one-hot-low or all ones
//  load_ack   out  1   1-cycle pulse: pending buffer has been copied to the display
// BEHAVIOUR
//  Reset (async, rst=1): div=0, idx=0, frame_cnt=0, blink_phase=0, active=16'h0000,
//   pending=16'h0000, pend=0; outputs an=4'b1111, number=4'h0, load_ack=0.
//  Divider: div counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 in the cycle where
//   div==REFRESH_DIV-1.
//  Digit index: idx (2 bits) increments on tick, 3->0 wrap. frame_end = tick & idx==3.
//  Outputs are registered and updated every cycle from the current idx:
//   number <= active[4*idx +: 4];
//   an <= (blink_phase & blink_en[idx]) ? 4'b1111 : ~(4'b0001 << idx).
//   The first clock after reset release gives an=4'b1110 and number=active[3:0].
//   Outputs follow an idx change one cycle after the tick.
//  Load buffering:
//   - load=1 -> pending<=digits_in, pend<=1.
//   - A load while pend=1 overwrites pending; the last load wins.
//   - On frame_end with pend=1: active<=pending, pend<=0, load_ack=1 next cycle.
//   - load in the same cycle as frame_end: the old pending goes to active and
//     load_ack pulses. The new digits_in goes to pending, pend stays 1 and it is
//     applied at the next frame_end.
//   - frame_end with pend=0: active is unchanged and there is no load_ack.
//  Blink: frame_cnt counts frame_end events 0..BLINK_FRAMES-1. At wrap,
//   blink_phase toggles. A blanked digit keeps its time slot, so scan timing never
//   changes. blink_en=0 always displays the digit.
//  Reset mid-frame: everything returns to reset values immediately. A pending load
//   is discarded and no load_ack is issued.
//  Fixed at 4 digits. REFRESH_DIV>=2 and BLINK_FRAMES>=1 are required.
// TESTING  (REFRESH_DIV=4, BLINK_FRAMES=2 unless noted)
//  1 Reset, then release -> an=1110, number=0. an then steps
//    1110->1101->1011->0111->1110, one step every 4 clks.
//  2 load digits_in=16'h4321 mid-frame -> display stays 0 until the frame_end.
//    load_ack pulses 1 clk later. The next frame shows number 1,2,3,4 on an
//    1110,1101,1011,0111.
//  3 Two loads (16'hAAAA then 16'h5555) in one frame -> only 5555 is displayed,
//    with a single load_ack.
//  4 load 16'h9999 coincident with frame_end while 4321 is pending -> 4321 is shown
//    with load_ack. 9999 is shown after the next frame_end with a second load_ack.
//  5 blink_en=4'b0100 -> digit 2 slot shows an=1111 for 2 frames, then 1011 for
//    2 frames, repeating. Other digits are unaffected.
//  6 Assert rst with pend=1 mid-frame -> an=1111 and number=0 immediately.
//    No load_ack is issued and active=0 after release.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Four-digit 7-segment scanner. Each frame it steps one active-low anode at a time,
// swaps in double-buffered digit loads at frame boundaries, and blanks digits chosen for blinking.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_digits_in,
    input  logic        i_load,
    input  logic [3:0]  i_blink_en,
    output logic [3:0]  o_number,
    output logic [3:0]  o_an,
    output logic        o_load_ack
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [FRM_W-1:0] r_frame_cnt;
    logic             r_blink_phase;
    logic [15:0]      r_active;
    logic [15:0]      r_pending;
    logic             r_pend;

    logic             w_tick;
    logic             w_frame_end;
    logic             w_blank;
    logic [3:0]       w_sel_nibble;
    logic [3:0]       w_an;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_frame_end = w_tick & (r_idx == 2'd3);
    assign w_blank     = r_blink_phase & i_blink_en[r_idx];
    assign w_an        = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);

    always_comb begin
        w_sel_nibble = r_active[3:0];
        case (r_idx)
            2'd0: w_sel_nibble = r_active[3:0];
            2'd1: w_sel_nibble = r_active[7:4];
            2'd2: w_sel_nibble = r_active[11:8];
            2'd3: w_sel_nibble = r_active[15:12];
            default: w_sel_nibble = r_active[3:0];
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div         <= '0;
            r_idx         <= 2'd0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_tick) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_frame_end) begin
                if (r_frame_cnt == FRM_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load coincident with frame_end still lands in pending; the old pending goes live.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active   <= 16'h0000;
            r_pending  <= 16'h0000;
            r_pend     <= 1'b0;
            o_load_ack <= 1'b0;
        end else begin
            o_load_ack <= w_frame_end & r_pend;
            if (w_frame_end && r_pend) begin
                r_active <= r_pending;
            end
            if (i_load) begin
                r_pending <= i_digits_in;
                r_pend    <= 1'b1;
            end else if (w_frame_end) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_number <= 4'h0;
            o_an     <= 4'b1111;
        end else begin
            o_number <= w_sel_nibble;
            o_an     <= w_an;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed load/blink/reset scenarios plus random traffic,
// compared each cycle against a model that derives scan position from elapsed clocks.
module tb_seg_scan_mux;

    localparam int R = 4;
    localparam int B = 2;
    localparam int FRAME = 4 * R;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blink_en;
    logic [3:0]  number;
    logic [3:0]  an;
    logic        load_ack;

    int n_vec;
    int n_err;

    int          k;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_pend;
    int          n_ack;

    seg_scan_mux #(.REFRESH_DIV(R), .BLINK_FRAMES(B)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_digits_in (digits_in),
        .i_load      (load),
        .i_blink_en  (blink_en),
        .o_number    (number),
        .o_an        (an),
        .o_load_ack  (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, got, exp);
        end
    endtask

    // Called at a negedge: drives inputs for the next rising edge, then checks after it.
    task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] be);
        int          idx;
        int          phase;
        bit          fe;
        logic [3:0]  e_num;
        logic [3:0]  e_an;
        logic        e_ack;
        load      = ld;
        digits_in = d;
        blink_en  = be;
        idx   = (k / R) % 4;
        phase = ((k / FRAME) / B) % 2;
        fe    = (k % FRAME) == FRAME - 1;
        e_num = m_active[4*idx +: 4];
        e_an  = (phase == 1 && be[idx]) ? 4'b1111 : ~(4'b0001 << idx);
        e_ack = fe && m_pend;
        if (fe && m_pend) begin
            m_active = m_pending;
            m_pend   = 1'b0;
        end
        if (ld) begin
            m_pending = d;
            m_pend    = 1'b1;
        end
        k++;
        @(posedge clk);
        @(negedge clk);
        chk("number", 16'(number), 16'(e_num));
        chk("an", 16'(an), 16'(e_an));
        chk("load_ack", 16'(load_ack), 16'(e_ack));
        if (load_ack) n_ack++;
    endtask

    task automatic idle(input int n, input logic [3:0] be);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, be);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_number", 16'(number), 16'h0);
        chk("rst_ack", 16'(load_ack), 16'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_an", 16'(an), 16'hF);
        rst       = 1'b0;
        k         = 0;
        m_active  = 16'h0;
        m_pending = 16'h0;
        m_pend    = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_ack = 0;
        load = 1'b0;
        digits_in = 16'h0;
        blink_en = 4'h0;
        rst = 1'b1;
        k = 0;
        m_active = 16'h0;
        m_pending = 16'h0;
        m_pend = 1'b0;
        @(negedge clk);
        do_reset();

        // Plain scan over two frames
        idle(2 * FRAME, 4'h0);

        // Mid-frame load, then a coincident load at frame_end while it is pending
        idle(5, 4'h0);
        cycle(1'b1, 16'h4321, 4'h0);
        while ((k % FRAME) != FRAME - 1) cycle(1'b0, 16'h0, 4'h0);
        n_ack = 0;
        cycle(1'b1, 16'h9999, 4'h0);
        idle(2 * FRAME, 4'h0);
        chk("acks_4321_9999", 16'(n_ack), 16'd2);

        // Two loads in one frame: last one wins with a single ack
        while ((k % FRAME) != 2) cycle(1'b0, 16'h0, 4'h0);
        n_ack = 0;
        cycle(1'b1, 16'hAAAA, 4'h0);
        idle(3, 4'h0);
        cycle(1'b1, 16'h5555, 4'h0);
        idle(2 * FRAME, 4'h0);
        chk("acks_aaaa_5555", 16'(n_ack), 16'd1);
        chk("active_5555", 16'(m_active), 16'h5555);

        // Blink on digit 2 through several blink periods
        idle(6 * FRAME, 4'b0100);

        // Randomised traffic
        begin
            logic [3:0] be;
            be = 4'h0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 49) == 0) be = 4'($urandom_range(0, 15));
                cycle(($urandom_range(0, 7) == 0), 16'($urandom), be);
            end
        end

        // Reset mid-frame with a load pending; nothing must leak through
        while ((k % FRAME) != 5) cycle(1'b0, 16'h0, 4'h0);
        cycle(1'b1, 16'hBEEF, 4'h0);
        idle(2, 4'h0);
        do_reset();
        n_ack = 0;
        idle(3 * FRAME, 4'h0);
        chk("acks_after_rst", 16'(n_ack), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
